// File: rtl/ahb_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter_pkg
// Shared AHB-Lite types and helpers for the bus arbiter slice.
//   HTRANS_E / HBURST_E / HRESP_E : AHB-Lite encodings, identical to the ones
//                                   used by the masters (master_package).
//   burst_beats()                 : beats remaining after the first beat of a
//                                   fixed-length burst (length - 1).
//   AHB_MAX_MASTERS               : upper bound on the number of masters.
// Optional feature macro used by the slice: AHB_ARB_HLOCK_EN.
// ----------------------------------------------------------------------------
package ahb_bus_arbiter_pkg;

  localparam int AHB_MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } HTRANS_E;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } HBURST_E;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } HRESP_E;

  // Undefined-length INCR counts as a single beat here; its lock comes from
  // the owner's request instead of the beat counter.
  function automatic logic [3:0] burst_beats(input HBURST_E burst);
    logic [3:0] beats;
    case (burst)
      BU_WRAP4,  BU_INCR4:  beats = 4'd3;
      BU_WRAP8,  BU_INCR8:  beats = 4'd7;
      BU_WRAP16, BU_INCR16: beats = 4'd15;
      default:              beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter_if
// Bundles the arbitration handshake between the bus side and the arbiter.
//   master modport : bus side; drives HBUSREQ and the muxed HTRANS/HBURST/
//                    HREADY/HRESP, observes HGRANT/HMASTER/HMASTER_DATA.
//   slave modport  : arbiter side; the reverse directions.
// With AHB_ARB_HLOCK_EN defined, HLOCK (per master) and HMASTLOCK are added.
// ----------------------------------------------------------------------------
interface ahb_bus_arbiter_if
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) ();

  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  HTRANS_E                HTRANS;
  HBURST_E                HBURST;
  logic                   HREADY;
  HRESP_E                 HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTER_DATA;
`ifdef AHB_ARB_HLOCK_EN
  logic [NUM_MASTERS-1:0] HLOCK;
  logic                   HMASTLOCK;
`endif

  modport master (
    output HBUSREQ, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_HLOCK_EN
    output HLOCK,
    input  HMASTLOCK,
`endif
    input  HGRANT, HMASTER, HMASTER_DATA
  );

  modport slave (
    input  HBUSREQ, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_HLOCK_EN
    input  HLOCK,
    output HMASTLOCK,
`endif
    output HGRANT, HMASTER, HMASTER_DATA
  );

endinterface

// File: rtl/ahb_burst_counter.sv
// ----------------------------------------------------------------------------
// ahb_burst_counter
// Tracks the beats still to be issued in the current fixed-length burst and
// reports whether the bus must stay with the current address-phase owner.
//   clk, rst_n : bus clock, asynchronous active-low reset
//   htrans     : muxed transfer type of the address-phase owner
//   hburst     : muxed burst type of the address-phase owner
//   hready     : muxed slave ready
//   hresp      : muxed slave response
//   owner_req  : HBUSREQ of the current address-phase owner
//   locked     : arbitration must not move the grant this cycle
// ----------------------------------------------------------------------------
module ahb_burst_counter
  import ahb_bus_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  HTRANS_E htrans,
  input  HBURST_E hburst,
  input  logic    hready,
  input  HRESP_E  hresp,
  input  logic    owner_req,
  output logic    locked
);

  logic [3:0] remain_q;
  logic [3:0] remain_d;   // remain_next: value remain takes at the next edge
  logic       incr_lock;

  always_comb begin
    remain_d = remain_q;
    if (!hready) begin
      // First error cycle aborts the burst so the bus can be re-arbitrated
      // as soon as the error response completes.
      if (hresp == RESP_ERROR) remain_d = 4'd0;
    end else begin
      case (htrans)
        TR_NONSEQ: remain_d = burst_beats(hburst);
        TR_SEQ:    remain_d = (remain_q == 4'd0) ? 4'd0 : remain_q - 4'd1;
        default:   remain_d = remain_q;
      endcase
    end
  end

  // An undefined-length INCR keeps the bus while its owner still asks for it.
  assign incr_lock = (hburst == BU_INCR) && (htrans != TR_IDLE) && owner_req;
  assign locked    = (remain_d != 4'd0) || incr_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) remain_q <= 4'd0;
    else        remain_q <= remain_d;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter
// Round-robin arbiter sharing one AHB-Lite bus between NUM_MASTERS masters.
// Never moves the grant inside a fixed-length burst.
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   bus (slave)   : HBUSREQ/HTRANS/HBURST/HREADY/HRESP in,
//                   HGRANT (one-hot next owner), HMASTER (address-phase
//                   owner), HMASTER_DATA (data-phase owner) out
// Optional macro AHB_ARB_HLOCK_EN adds HLOCK in and HMASTLOCK out.
// ----------------------------------------------------------------------------
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);

  localparam int                    MW      = $clog2(NUM_MASTERS);
  localparam logic [MW-1:0]         DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
  logic [MW-1:0]          winner, cand, grant_idx;
  logic                   found;
  logic                   burst_locked;
  logic                   locked;

  function automatic logic [MW-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = idx | MW'(i);
    end
    return idx;
  endfunction

  ahb_burst_counter u_burst_counter (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .htrans    (bus.HTRANS),
    .hburst    (bus.HBURST),
    .hready    (bus.HREADY),
    .hresp     (bus.HRESP),
    .owner_req (bus.HBUSREQ[hmaster_q]),
    .locked    (burst_locked)
  );

`ifdef AHB_ARB_HLOCK_EN
  logic hmastlock_q, hmastlock_d;
  assign locked = burst_locked || bus.HLOCK[hmaster_q];
`else
  assign locked = burst_locked;
`endif

  assign grant_idx = onehot_to_idx(grant_q);

  // Search starts just after the current owner and ends at the owner itself,
  // so a sole requesting owner keeps the bus.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(hmaster_q) + i) % NUM_MASTERS);
      if (!found && bus.HBUSREQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d        = grant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    if (bus.HREADY) begin
      if (!locked) grant_d = NUM_MASTERS'(1) << winner;
      hmaster_d      = grant_idx;
      hmaster_data_d = hmaster_q;
    end
  end

`ifdef AHB_ARB_HLOCK_EN
  always_comb begin
    hmastlock_d = hmastlock_q;
    if (bus.HREADY) hmastlock_d = bus.HLOCK[grant_idx];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hmastlock_q <= 1'b0;
    else          hmastlock_q <= hmastlock_d;
  end

  assign bus.HMASTLOCK = hmastlock_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q        <= DEF_OH;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
    end else begin
      grant_q        <= grant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
    end
  end

  assign bus.HGRANT       = grant_q;
  assign bus.HMASTER      = hmaster_q;
  assign bus.HMASTER_DATA = hmaster_data_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_bus_arbiter
// Directed, table-driven bench for ahb_bus_arbiter with two masters parked on
// master 0. Each table row is one clock: inputs applied on the falling edge,
// expected HGRANT/HMASTER/HMASTER_DATA checked just after the rising edge.
// Hand-written sequences cover asynchronous reset mid-burst and, when
// AHB_ARB_HLOCK_EN is defined, HLOCK.
// ----------------------------------------------------------------------------
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  logic HCLK;
  logic HRESETn;

  ahb_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string     tag;
    logic [1:0] req;
    HTRANS_E   tr;
    HBURST_E   bu;
    logic      rdy;
    HRESP_E    rsp;
    logic [1:0] g;
    logic      hm;
    logic      hd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input string tag, input logic [1:0] req, input HTRANS_E tr,
                     input HBURST_E bu, input logic rdy, input HRESP_E rsp,
                     input logic [1:0] g, input logic hm, input logic hd);
    vec_t v;
    v.tag = tag; v.req = req; v.tr = tr; v.bu = bu; v.rdy = rdy; v.rsp = rsp;
    v.g = g; v.hm = hm; v.hd = hd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] g, input logic hm, input logic hd);
    checks++;
    if (bus.HGRANT !== g || bus.HMASTER !== hm || bus.HMASTER_DATA !== hd) begin
      errors++;
      $display("FAIL %s: got HGRANT=%b HMASTER=%0d HMASTER_DATA=%0d, expected HGRANT=%b HMASTER=%0d HMASTER_DATA=%0d",
               name, bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, g, hm, hd);
    end
  endtask

  task automatic drive(input logic [1:0] req, input HTRANS_E tr, input HBURST_E bu,
                       input logic rdy, input HRESP_E rsp);
    bus.HBUSREQ = req;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    bus.HRESP   = rsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    drive(2'b00, TR_IDLE, BU_SINGLE, 1'b1, RESP_OKAY);
`ifdef AHB_ARB_HLOCK_EN
    bus.HLOCK = 2'b00;
`endif

    // Parked idle bus
    for (int i = 0; i < 10; i++)
      add("idle", 2'b00, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // M1 requests alone: grant, address owner, data owner one edge apart
    add("m1_req_g",  2'b10, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b10, 0, 0);
    add("m1_req_hm", 2'b10, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 0);
    add("m1_req_hd", 2'b10, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 1);
    add("m1_rel0",   2'b00, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 1);
    add("m1_rel1",   2'b00, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    add("m1_rel2",   2'b00, TR_IDLE, BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // M0 INCR4 while M1 requests: handover on the edge accepting beat 4
    add("incr4_b1",  2'b11, TR_NONSEQ, BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    add("incr4_b2",  2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    add("incr4_b3",  2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    add("incr4_b4",  2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b10, 0, 0);
    add("incr4_ho",  2'b11, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 0);
    add("incr4_m1",  2'b01, TR_NONSEQ, BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 1);
    add("incr4_bk",  2'b01, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    add("incr4_end", 2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // Same INCR4 with three wait states on beat 2
    add("wait_b1",   2'b11, TR_NONSEQ, BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++)
      add("wait_ws", 2'b11, TR_SEQ,    BU_INCR4, 0, RESP_OKAY, 2'b01, 0, 0);
    add("wait_b2",   2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    add("wait_b3",   2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b01, 0, 0);
    add("wait_b4",   2'b11, TR_SEQ,    BU_INCR4, 1, RESP_OKAY, 2'b10, 0, 0);
    add("wait_ho",   2'b11, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 0);
    add("wait_bk",   2'b01, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 1);
    add("wait_e1",   2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    add("wait_e2",   2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // INCR8 aborted by an ERROR on beat 3
    add("err_b1",    2'b11, TR_NONSEQ, BU_INCR8, 1, RESP_OKAY,  2'b01, 0, 0);
    add("err_b2",    2'b11, TR_SEQ,    BU_INCR8, 1, RESP_OKAY,  2'b01, 0, 0);
    add("err_b3",    2'b11, TR_SEQ,    BU_INCR8, 1, RESP_OKAY,  2'b01, 0, 0);
    add("err_1st",   2'b11, TR_SEQ,    BU_INCR8, 0, RESP_ERROR, 2'b01, 0, 0);
    add("err_2nd",   2'b11, TR_IDLE,   BU_INCR8, 1, RESP_ERROR, 2'b10, 0, 0);
    add("err_ho",    2'b11, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 0);
    add("err_e1",    2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 1);
    add("err_e2",    2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    add("err_e3",    2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // Both masters request with SINGLE transfers: ownership alternates
    for (int i = 0; i < 2; i++) begin
      add("rr_a", 2'b11, TR_NONSEQ, BU_SINGLE, 1, RESP_OKAY, 2'b10, 0, 0);
      add("rr_b", 2'b11, TR_NONSEQ, BU_SINGLE, 1, RESP_OKAY, 2'b10, 1, 0);
      add("rr_c", 2'b11, TR_NONSEQ, BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 1);
      add("rr_d", 2'b11, TR_NONSEQ, BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    end
    add("rr_end",    2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);
    // Undefined-length INCR held while its owner keeps requesting
    add("incr_b1",   2'b11, TR_NONSEQ, BU_INCR,   1, RESP_OKAY, 2'b01, 0, 0);
    add("incr_b2",   2'b11, TR_SEQ,    BU_INCR,   1, RESP_OKAY, 2'b01, 0, 0);
    add("incr_rel",  2'b10, TR_SEQ,    BU_INCR,   1, RESP_OKAY, 2'b10, 0, 0);
    add("incr_e1",   2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 1, 0);
    add("incr_e2",   2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 1);
    add("incr_e3",   2'b00, TR_IDLE,   BU_SINGLE, 1, RESP_OKAY, 2'b01, 0, 0);

    repeat (2) @(posedge HCLK);
    #1 chk("in_reset", 2'b01, 0, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1 chk("reset_rel", 2'b01, 0, 0);

    foreach (vecs[i]) begin
      @(negedge HCLK);
      drive(vecs[i].req, vecs[i].tr, vecs[i].bu, vecs[i].rdy, vecs[i].rsp);
      @(posedge HCLK);
      #1 chk($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].g, vecs[i].hm, vecs[i].hd);
    end

    // Reset in the middle of an INCR16 abandons the burst
    @(negedge HCLK);
    drive(2'b10, TR_NONSEQ, BU_INCR16, 1'b1, RESP_OKAY);
    @(posedge HCLK);
    #1 chk("rst_burst_lock", 2'b01, 0, 0);
    #2 HRESETn = 1'b0;
    #1 chk("rst_burst_async", 2'b01, 0, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(2'b10, TR_SEQ, BU_INCR16, 1'b1, RESP_OKAY);
    @(posedge HCLK);
    #1 chk("rst_burst_gone", 2'b10, 0, 0);
    #2 HRESETn = 1'b0;
    #1 chk("rst_async_grant", 2'b01, 0, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(2'b00, TR_IDLE, BU_SINGLE, 1'b1, RESP_OKAY);
    @(posedge HCLK);
    #1 chk("rst_idle", 2'b01, 0, 0);

`ifdef AHB_ARB_HLOCK_EN
    // HLOCK from the owner holds the bus and is reflected on HMASTLOCK
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      bus.HLOCK = (i < 3) ? 2'b01 : 2'b00;
      drive(2'b11, TR_IDLE, BU_SINGLE, 1'b1, RESP_OKAY);
      @(posedge HCLK);
      #1;
      chk($sformatf("hlock_grant[%0d]", i), (i < 3) ? 2'b01 : 2'b10, 0, 0);
      checks++;
      if (bus.HMASTLOCK !== ((i < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL hlock_mastlock[%0d]: got HMASTLOCK=%b, expected %b",
                 i, bus.HMASTLOCK, (i < 3) ? 1'b1 : 1'b0);
      end
    end
    @(negedge HCLK);
    bus.HLOCK = 2'b00;
    drive(2'b00, TR_IDLE, BU_SINGLE, 1'b1, RESP_OKAY);
`endif

    repeat (2) @(posedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
